// File: rtl/nonrestoring_div_pipe_if.sv
// Operand/result handshake bundle for the non-restoring divider.
// The master side supplies operands and consumes results; the divider is the slave.
interface nonrestoring_div_pipe_if #(
  parameter int WIDTH = 512
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;
  logic             busy;

  modport master (
    output in_valid, dividend, divisor, out_ready,
    input  in_ready, out_valid, quotient, remainder, div_by_zero, busy
  );

  modport slave (
    input  in_valid, dividend, divisor, out_ready,
    output in_ready, out_valid, quotient, remainder, div_by_zero, busy
  );
endinterface

// File: rtl/nonrestoring_div_pipe.sv
// Iterative non-restoring unsigned divider retiring STEPS quotient bits per clock,
// with valid/ready on both sides and a one-cycle divide-by-zero short-circuit.
module nonrestoring_div_pipe #(
  parameter int WIDTH = 512,
  parameter int STEPS = 1
) (
  input logic clk,
  input logic rst_n,
  nonrestoring_div_pipe_if.slave bus
);
  localparam int ITERS = WIDTH / STEPS;
  localparam int CNT_W = $clog2(ITERS + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ITERS);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  // IDLE accept operands | RUN iterate | FIX correct negative A | DONE present result
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX, S_DONE} state_t;

  state_t           r_state;
  logic [WIDTH:0]   r_a;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_m;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_quotient;
  logic [WIDTH-1:0] r_remainder;
  logic             r_dbz;
  logic             r_out_valid;
  logic             r_in_ready;
  logic             r_busy;

  logic [WIDTH:0]   w_a;
  logic [WIDTH:0]   w_sh;
  logic [WIDTH-1:0] w_q;
  logic [WIDTH-1:0] w_rem;

  // A wraps modulo 2^(WIDTH+1) on the shift; each true result lies in [-M, M) so it is exact.
  always_comb begin
    w_a  = r_a;
    w_q  = r_q;
    w_sh = '0;
    for (int i = 0; i < STEPS; i++) begin
      w_sh = {w_a[WIDTH-1:0], w_q[WIDTH-1]};
      if (!w_a[WIDTH]) w_a = w_sh - {1'b0, r_m};
      else             w_a = w_sh + {1'b0, r_m};
      w_q = {w_q[WIDTH-2:0], ~w_a[WIDTH]};
    end
  end

  assign w_rem = r_a[WIDTH] ? (r_a[WIDTH-1:0] + r_m) : r_a[WIDTH-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_a         <= '0;
      r_q         <= '0;
      r_m         <= '0;
      r_cnt       <= '0;
      r_quotient  <= '0;
      r_remainder <= '0;
      r_dbz       <= 1'b0;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b1;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.in_valid) begin
            r_q        <= bus.dividend;
            r_m        <= bus.divisor;
            r_a        <= '0;
            r_cnt      <= CNT_LOAD;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
            if (bus.divisor == '0) begin
              r_quotient  <= '1;
              r_remainder <= bus.dividend;
              r_dbz       <= 1'b1;
              r_out_valid <= 1'b1;
              r_state     <= S_DONE;
            end else begin
              r_state <= S_RUN;
            end
          end
        end
        S_RUN: begin
          r_a   <= w_a;
          r_q   <= w_q;
          r_cnt <= r_cnt - CNT_ONE;
          if (r_cnt == CNT_ONE) r_state <= S_FIX;
        end
        S_FIX: begin
          r_quotient  <= r_q;
          r_remainder <= w_rem;
          r_dbz       <= 1'b0;
          r_out_valid <= 1'b1;
          r_state     <= S_DONE;
        end
        S_DONE: begin
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready    = r_in_ready;
  assign bus.out_valid   = r_out_valid;
  assign bus.quotient    = r_quotient;
  assign bus.remainder   = r_remainder;
  assign bus.div_by_zero = r_dbz;
  assign bus.busy        = r_busy;
endmodule

// File: tb/tb_nonrestoring_div_pipe.sv
// Scoreboard bench: three divider configurations (8/1, 8/2, 512/8) checked against
// a division reference model, plus latency, back-pressure and async-reset checks.
module tb_nonrestoring_div_pipe;
  localparam int LAT_A = 8 / 1 + 2;
  localparam int LAT_B = 8 / 2 + 2;
  localparam int LAT_C = 512 / 8 + 2;

  typedef struct {
    logic [511:0] q;
    logic [511:0] r;
    logic         dbz;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t sb_a[$];
  exp_t sb_b[$];
  exp_t sb_c[$];

  always #5 clk = ~clk;

  nonrestoring_div_pipe_if #(.WIDTH(8))   bus_a ();
  nonrestoring_div_pipe_if #(.WIDTH(8))   bus_b ();
  nonrestoring_div_pipe_if #(.WIDTH(512)) bus_c ();

  nonrestoring_div_pipe #(.WIDTH(8),   .STEPS(1)) u_dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a.slave));
  nonrestoring_div_pipe #(.WIDTH(8),   .STEPS(2)) u_dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b.slave));
  nonrestoring_div_pipe #(.WIDTH(512), .STEPS(8)) u_dut_c (.clk(clk), .rst_n(rst_n), .bus(bus_c.slave));

  task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cmp_res(input string tag, input exp_t e, input logic [511:0] q, r, input logic dbz);
    chk({tag, "_quotient"}, q, e.q);
    chk({tag, "_remainder"}, r, e.r);
    chk({tag, "_div_by_zero"}, 512'(dbz), 512'(e.dbz));
  endtask

  function automatic exp_t model(input logic [511:0] n, d, input int w);
    exp_t e;
    logic [511:0] mask;
    mask = '1;
    mask = mask >> (512 - w);
    e.dbz = (d == '0);
    e.q   = e.dbz ? mask : n / d;
    e.r   = e.dbz ? n : n % d;
    return e;
  endfunction

  function automatic logic [511:0] rand512();
    logic [511:0] v;
    for (int i = 0; i < 16; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (rst_n && bus_a.out_valid && bus_a.out_ready) begin
      if (sb_a.size() == 0) chk("a_unexpected_result", 1, 0);
      else cmp_res("a", sb_a.pop_front(), 512'(bus_a.quotient), 512'(bus_a.remainder), bus_a.div_by_zero);
    end
    if (rst_n && bus_b.out_valid && bus_b.out_ready) begin
      if (sb_b.size() == 0) chk("b_unexpected_result", 1, 0);
      else cmp_res("b", sb_b.pop_front(), 512'(bus_b.quotient), 512'(bus_b.remainder), bus_b.div_by_zero);
    end
    if (rst_n && bus_c.out_valid && bus_c.out_ready) begin
      if (sb_c.size() == 0) chk("c_unexpected_result", 1, 0);
      else cmp_res("c", sb_c.pop_front(), bus_c.quotient, bus_c.remainder, bus_c.div_by_zero);
    end
  end

  task automatic op_a(input logic [7:0] n, d, input int hold);
    int lat;
    exp_t e;
    e = model(512'(n), 512'(d), 8);
    chk("a_in_ready_idle", 512'(bus_a.in_ready), 1);
    sb_a.push_back(e);
    bus_a.dividend  = n;
    bus_a.divisor   = d;
    bus_a.in_valid  = 1'b1;
    bus_a.out_ready = (hold == 0);
    tick();
    bus_a.in_valid = 1'b0;
    bus_a.dividend = ~n;
    bus_a.divisor  = n ^ 8'h3C;
    chk("a_busy", 512'(bus_a.busy), 1);
    lat = 1;
    while (!bus_a.out_valid && lat < 100) begin
      tick();
      lat++;
    end
    chk("a_latency", 512'(lat), 512'((d == 0) ? 1 : LAT_A));
    for (int i = 0; i < hold; i++) begin
      chk("a_hold_valid", 512'(bus_a.out_valid), 1);
      chk("a_hold_quotient", 512'(bus_a.quotient), e.q);
      chk("a_hold_remainder", 512'(bus_a.remainder), e.r);
      chk("a_hold_in_ready", 512'(bus_a.in_ready), 0);
      tick();
    end
    bus_a.out_ready = 1'b1;
    tick();
    bus_a.out_ready = 1'b0;
    chk("a_valid_drop", 512'(bus_a.out_valid), 0);
    chk("a_in_ready_back", 512'(bus_a.in_ready), 1);
    chk("a_busy_clear", 512'(bus_a.busy), 0);
    chk("a_quotient_kept", 512'(bus_a.quotient), e.q);
  endtask

  task automatic op_b(input logic [7:0] n, d);
    int lat;
    chk("b_in_ready_idle", 512'(bus_b.in_ready), 1);
    sb_b.push_back(model(512'(n), 512'(d), 8));
    bus_b.dividend  = n;
    bus_b.divisor   = d;
    bus_b.in_valid  = 1'b1;
    bus_b.out_ready = 1'b0;
    tick();
    bus_b.in_valid = 1'b0;
    bus_b.dividend = 8'($urandom);
    bus_b.divisor  = 8'($urandom);
    lat = 1;
    while (!bus_b.out_valid && lat < 100) begin
      tick();
      lat++;
    end
    chk("b_latency", 512'(lat), 512'((d == 0) ? 1 : LAT_B));
    repeat ($urandom_range(0, 2)) tick();
    bus_b.out_ready = 1'b1;
    tick();
    bus_b.out_ready = 1'b0;
    chk("b_valid_drop", 512'(bus_b.out_valid), 0);
  endtask

  task automatic op_c(input logic [511:0] n, d);
    int lat;
    chk("c_in_ready_idle", 512'(bus_c.in_ready), 1);
    sb_c.push_back(model(n, d, 512));
    bus_c.dividend  = n;
    bus_c.divisor   = d;
    bus_c.in_valid  = 1'b1;
    bus_c.out_ready = 1'b0;
    tick();
    bus_c.in_valid = 1'b0;
    bus_c.dividend = rand512();
    bus_c.divisor  = rand512();
    lat = 1;
    while (!bus_c.out_valid && lat < 200) begin
      tick();
      lat++;
    end
    chk("c_latency", 512'(lat), 512'((d == '0) ? 1 : LAT_C));
    repeat ($urandom_range(0, 2)) tick();
    bus_c.out_ready = 1'b1;
    tick();
    bus_c.out_ready = 1'b0;
    chk("c_valid_drop", 512'(bus_c.out_valid), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected summary");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [511:0] n;
    logic [511:0] d;
    logic [511:0] msb;
    bus_a.in_valid = 1'b0; bus_a.out_ready = 1'b0; bus_a.dividend = '0; bus_a.divisor = '0;
    bus_b.in_valid = 1'b0; bus_b.out_ready = 1'b0; bus_b.dividend = '0; bus_b.divisor = '0;
    bus_c.in_valid = 1'b0; bus_c.out_ready = 1'b0; bus_c.dividend = '0; bus_c.divisor = '0;
    repeat (3) tick();
    chk("rst_in_ready", 512'(bus_a.in_ready), 1);
    chk("rst_out_valid", 512'(bus_a.out_valid), 0);
    chk("rst_busy", 512'(bus_a.busy), 0);
    chk("rst_quotient", 512'(bus_a.quotient), 0);
    chk("rst_remainder", 512'(bus_a.remainder), 0);
    chk("rst_div_by_zero", 512'(bus_a.div_by_zero), 0);
    rst_n = 1'b1;
    tick();

    op_a(8'd100, 8'd7, 0);
    op_a(8'd37, 8'd0, 0);
    op_a(8'd50, 8'd5, 20);
    op_a(8'd255, 8'd255, 0);
    op_a(8'd254, 8'd255, 0);

    // Abort a division mid-RUN; its result must never surface.
    bus_a.dividend = 8'd200;
    bus_a.divisor  = 8'd3;
    bus_a.in_valid = 1'b1;
    tick();
    bus_a.in_valid = 1'b0;
    repeat (3) tick();
    #2 rst_n = 1'b0;
    #1;
    chk("abort_out_valid", 512'(bus_a.out_valid), 0);
    chk("abort_in_ready", 512'(bus_a.in_ready), 1);
    chk("abort_busy", 512'(bus_a.busy), 0);
    chk("abort_quotient", 512'(bus_a.quotient), 0);
    chk("abort_remainder", 512'(bus_a.remainder), 0);
    chk("abort_div_by_zero", 512'(bus_a.div_by_zero), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) begin
      tick();
      chk("abort_no_stale_valid", 512'(bus_a.out_valid), 0);
    end
    op_a(8'd9, 8'd4, 0);

    op_b(8'd255, 8'd255);
    op_b(8'd254, 8'd255);
    op_b(8'd37, 8'd0);
    op_b(8'd0, 8'd1);
    for (int k = 0; k < 150; k++) op_b(8'($urandom), 8'($urandom_range(0, 255)));

    msb = '0;
    msb[511] = 1'b1;
    for (int k = 0; k < 150; k++) begin
      case (k % 7)
        0: begin n = rand512(); d = 512'd1; end
        1: begin d = rand512(); n = d; end
        2: begin d = rand512() | msb; n = rand512() >> 1; end
        3: begin n = rand512(); d = msb + 512'($urandom_range(0, 1000)); end
        4: begin n = rand512(); d = rand512() >> $urandom_range(0, 511); end
        5: begin n = '1; d = (k % 2 == 1) ? '1 : rand512() >> $urandom_range(300, 511); end
        default: begin n = rand512(); d = (k % 3 == 0) ? '0 : rand512() >> $urandom_range(1, 500); end
      endcase
      op_c(n, d);
    end

    repeat (3) tick();
    chk("scoreboard_drained", 512'(sb_a.size() + sb_b.size() + sb_c.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
